// File: rtl/lb_byte_master_if.sv
// Byte command/response streams and local-bus signals of lb_byte_master.
// master: the byte master itself; slave: the transport + CSR side facing it.
interface lb_byte_master_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 16,
   parameter int STRB_W = DATA_W / 8
);
   logic [7:0]        cmd_data;
   logic              cmd_valid;
   logic              cmd_ready;
   logic [7:0]        rsp_data;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [ADDR_W-1:0] lb_waddr;
   logic [DATA_W-1:0] lb_wdata;
   logic              lb_wen;
   logic [STRB_W-1:0] lb_wstrb;
   logic              lb_wready;
   logic [ADDR_W-1:0] lb_raddr;
   logic              lb_ren;
   logic [DATA_W-1:0] lb_rdata;
   logic              lb_rvalid;

   modport master (
      input  cmd_data, cmd_valid, rsp_ready, lb_wready, lb_rdata, lb_rvalid,
      output cmd_ready, rsp_data, rsp_valid,
      output lb_waddr, lb_wdata, lb_wen, lb_wstrb, lb_raddr, lb_ren
   );

   modport slave (
      output cmd_data, cmd_valid, rsp_ready, lb_wready, lb_rdata, lb_rvalid,
      input  cmd_ready, rsp_data, rsp_valid,
      input  lb_waddr, lb_wdata, lb_wen, lb_wstrb, lb_raddr, lb_ren
   );
endinterface

// File: rtl/lb_byte_master.sv
// Local-bus initiator: decodes a byte command stream into LB writes/reads and
// returns a status byte (plus read data, LSB first) on the response stream.
module lb_byte_master #(
   parameter int ADDR_W  = 8,
   parameter int DATA_W  = 16,
   parameter int STRB_W  = DATA_W / 8,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst,
   lb_byte_master_if.master  bus,
   output logic              busy
);
   localparam int unsigned AB    = ADDR_W / 8;
   localparam int unsigned DB    = DATA_W / 8;
   localparam int          TMO_W = $clog2(TIMEOUT + 1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_ADDR  = 3'd1;
   localparam logic [2:0] S_WDATA = 3'd2;
   localparam logic [2:0] S_WSTRB = 3'd3;
   localparam logic [2:0] S_WRITE = 3'd4;
   localparam logic [2:0] S_READ  = 3'd5;
   localparam logic [2:0] S_RESP  = 3'd6;

   localparam logic [7:0] OP_WRITE = 8'h01;
   localparam logic [7:0] OP_READ  = 8'h02;

   logic [2:0]        state;
   logic [7:0]        byte_cnt;
   logic [7:0]        rsp_last;
   logic [7:0]        status;
   logic              is_read;
   logic [ADDR_W-1:0] addr_r;
   logic [DATA_W-1:0] wdata_r;
   logic [DATA_W-1:0] rdata_r;
   logic [STRB_W-1:0] strb_r;
   logic              wen_r;
   logic              ren_r;
   logic [TMO_W-1:0]  tmo;

   logic              cmd_acc;
   logic              rsp_acc;
   logic              tmo_hit;
   logic [DATA_W+7:0] rsp_word;
   logic [7:0]        rsp_byte;

   // rst gates the handshakes so nothing is accepted or offered in the reset cycle
   assign bus.cmd_ready = !rst && (state == S_IDLE || state == S_ADDR ||
                                   state == S_WDATA || state == S_WSTRB);
   assign bus.rsp_valid = !rst && (state == S_RESP);
   assign cmd_acc       = bus.cmd_valid && bus.cmd_ready;
   assign rsp_acc       = bus.rsp_valid && bus.rsp_ready;
   assign tmo_hit       = (tmo == TMO_W'(TIMEOUT));
   assign rsp_word      = {rdata_r, status};
   assign bus.rsp_data  = bus.rsp_valid ? rsp_byte : '0;

   assign bus.lb_waddr  = addr_r;
   assign bus.lb_raddr  = addr_r;
   assign bus.lb_wdata  = wdata_r;
   assign bus.lb_wstrb  = strb_r;
   assign bus.lb_wen    = wen_r;
   assign bus.lb_ren    = ren_r;
   assign busy          = (state != S_IDLE);

   always_comb begin
      rsp_byte = '0;
      for (int unsigned i = 0; i <= DB; i++)
         if (byte_cnt == 8'(i)) rsp_byte = rsp_word[8*i +: 8];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         byte_cnt <= '0;
         rsp_last <= '0;
         status   <= '0;
         is_read  <= 1'b0;
         addr_r   <= '0;
         wdata_r  <= '0;
         rdata_r  <= '0;
         strb_r   <= '0;
         wen_r    <= 1'b0;
         ren_r    <= 1'b0;
         tmo      <= '0;
      end else begin
         case (state)
            S_IDLE: if (cmd_acc) begin
               byte_cnt <= '0;
               if (bus.cmd_data == OP_WRITE) begin
                  is_read <= 1'b0;
                  state   <= S_ADDR;
               end else if (bus.cmd_data == OP_READ) begin
                  is_read <= 1'b1;
                  state   <= S_ADDR;
               end else begin
                  status   <= 8'hFF;
                  rsp_last <= '0;
                  state    <= S_RESP;
               end
            end
            S_ADDR: if (cmd_acc) begin
               for (int unsigned i = 0; i < AB; i++)
                  if (byte_cnt == 8'(i)) addr_r[8*i +: 8] <= bus.cmd_data;
               if (byte_cnt == 8'(AB - 1)) begin
                  byte_cnt <= '0;
                  tmo      <= '0;
                  if (is_read) begin
                     ren_r <= 1'b1;
                     state <= S_READ;
                  end else begin
                     state <= S_WDATA;
                  end
               end else begin
                  byte_cnt <= byte_cnt + 8'd1;
               end
            end
            S_WDATA: if (cmd_acc) begin
               for (int unsigned i = 0; i < DB; i++)
                  if (byte_cnt == 8'(i)) wdata_r[8*i +: 8] <= bus.cmd_data;
               if (byte_cnt == 8'(DB - 1)) begin
                  byte_cnt <= '0;
                  state    <= S_WSTRB;
               end else begin
                  byte_cnt <= byte_cnt + 8'd1;
               end
            end
            S_WSTRB: if (cmd_acc) begin
               strb_r <= bus.cmd_data[STRB_W-1:0];
               wen_r  <= 1'b1;
               tmo    <= '0;
               state  <= S_WRITE;
            end
            // handshake is tested before the timeout so it wins a same-cycle tie
            S_WRITE: begin
               if (bus.lb_wready || tmo_hit) begin
                  wen_r    <= 1'b0;
                  status   <= bus.lb_wready ? 8'h00 : 8'h01;
                  rsp_last <= '0;
                  byte_cnt <= '0;
                  state    <= S_RESP;
               end else begin
                  tmo <= tmo + 1'b1;
               end
            end
            S_READ: begin
               if (bus.lb_rvalid || tmo_hit) begin
                  ren_r    <= 1'b0;
                  status   <= bus.lb_rvalid ? 8'h00 : 8'h01;
                  rdata_r  <= bus.lb_rvalid ? bus.lb_rdata : '0;
                  rsp_last <= 8'(DB);
                  byte_cnt <= '0;
                  state    <= S_RESP;
               end else begin
                  tmo <= tmo + 1'b1;
               end
            end
            S_RESP: if (rsp_acc) begin
               if (byte_cnt == rsp_last) begin
                  byte_cnt <= '0;
                  state    <= S_IDLE;
               end else begin
                  byte_cnt <= byte_cnt + 8'd1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_lb_byte_master.sv
// Randomised bench for lb_byte_master: byte-level command driver, LB slave with
// programmable latency, and a transaction-level reference model.
module tb_lb_byte_master;
   localparam int ADDR_W  = 8;
   localparam int DATA_W  = 16;
   localparam int STRB_W  = 2;
   localparam int TIMEOUT = 255;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic busy;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;

   lb_byte_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STRB_W(STRB_W)) bus ();

   lb_byte_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STRB_W(STRB_W), .TIMEOUT(TIMEOUT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus),
      .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct packed {
      int              nrsp;
      logic [3:0][7:0] rsp;
      int              len;
      int              dly;
      logic [7:0]      addr;
      logic [15:0]     data;
      logic [1:0]      strb;
      bit              stable;
      bit              held_ok;
      bit              tail_bad;
      bit              send_ok;
      int              delta;
   } obs_t;

   // LB slave: answers after sl_lat extra cycles of request, records what it saw
   int          sl_lat = 0;
   bit          sl_never = 1'b0;
   logic [15:0] sl_rdata = '0;
   int          w_run = 0, w_len = 0, w_first = 0, w_count = 0;
   int          r_run = 0, r_len = 0, r_first = 0, r_count = 0;
   logic [7:0]  w_addr = '0, r_addr = '0;
   logic [15:0] w_data = '0;
   logic [1:0]  w_strb = '0;
   bit          w_stable = 1'b0, r_stable = 1'b0;
   bit          ready_bad = 1'b0;

   initial begin
      bus.lb_wready = 1'b0;
      bus.lb_rvalid = 1'b0;
      bus.lb_rdata  = '0;
      forever begin
         @(negedge clk);
         if (bus.lb_wen) begin
            if (w_run == 0) begin
               w_first = cyc; w_addr = bus.lb_waddr; w_data = bus.lb_wdata;
               w_strb = bus.lb_wstrb; w_stable = 1'b1;
            end else if (bus.lb_waddr !== w_addr || bus.lb_wdata !== w_data || bus.lb_wstrb !== w_strb)
               w_stable = 1'b0;
            w_run++;
            if (bus.cmd_ready) ready_bad = 1'b1;
            bus.lb_wready = !sl_never && (w_run == sl_lat + 1);
         end else begin
            if (w_run != 0) begin w_len = w_run; w_count++; end
            w_run = 0;
            bus.lb_wready = 1'b0;
         end
         if (bus.lb_ren) begin
            if (r_run == 0) begin
               r_first = cyc; r_addr = bus.lb_raddr; r_stable = 1'b1;
            end else if (bus.lb_raddr !== r_addr)
               r_stable = 1'b0;
            r_run++;
            if (bus.cmd_ready) ready_bad = 1'b1;
            bus.lb_rvalid = !sl_never && (r_run == sl_lat + 1);
            bus.lb_rdata  = bus.lb_rvalid ? sl_rdata : 16'($urandom);
         end else begin
            if (r_run != 0) begin r_len = r_run; r_count++; end
            r_run = 0;
            // stray rvalid noise while no read is outstanding
            bus.lb_rvalid = ($urandom_range(0, 3) == 0);
            bus.lb_rdata  = 16'($urandom);
         end
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic void model(input logic [7:0] op, input logic [15:0] rd, input int lat,
                                 input bit never, output int n, output logic [31:0] rsp,
                                 output int len, output int used);
      bit          ok;
      logic [15:0] v;
      ok = !never && (lat <= TIMEOUT);
      v  = ok ? rd : 16'h0000;
      if (op == 8'h01) begin
         n = 1; rsp = {24'h0, ok ? 8'h00 : 8'h01}; used = 1;
         len = ok ? lat + 1 : TIMEOUT + 1;
      end else if (op == 8'h02) begin
         n = 3; rsp = {8'h00, v, ok ? 8'h00 : 8'h01}; used = 1;
         len = ok ? lat + 1 : TIMEOUT + 1;
      end else begin
         n = 1; rsp = 32'h0000_00FF; len = 0; used = 0;
      end
   endfunction

   task automatic send_byte(input logic [7:0] b, output bit ok, output int acc);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      bus.cmd_data  = b;
      bus.cmd_valid = 1'b1;
      ok  = 1'b0;
      acc = 0;
      for (int i = 0; i < 600; i++) begin
         if (bus.cmd_ready) begin
            ok  = 1'b1;
            acc = cyc;
            @(negedge clk);
            break;
         end
         @(negedge clk);
      end
      bus.cmd_valid = 1'b0;
      bus.cmd_data  = 8'($urandom);
   endtask

   task automatic do_txn(input logic [7:0] op, input logic [7:0] addr, input logic [15:0] data,
                         input logic [7:0] strb, input int lat, input bit never, input int stall,
                         input int exp_n, output obs_t o);
      bit         ok, rdy, pv, pa;
      int         acc, wc0, rc0, got, scnt;
      logic [7:0] pd;
      o = '0;
      sl_lat = lat; sl_never = never; sl_rdata = data;
      wc0 = w_count; rc0 = r_count;
      o.send_ok = 1'b1;
      send_byte(op, ok, acc); o.send_ok &= ok;
      if (op == 8'h01 || op == 8'h02) begin send_byte(addr, ok, acc); o.send_ok &= ok; end
      if (op == 8'h01) begin
         send_byte(data[7:0], ok, acc);  o.send_ok &= ok;
         send_byte(data[15:8], ok, acc); o.send_ok &= ok;
         send_byte(strb, ok, acc);       o.send_ok &= ok;
      end
      got = 0; scnt = 0; pv = 1'b0; pa = 1'b0; pd = '0;
      o.held_ok = 1'b1;
      for (int c = 0; c < 3000 && got < exp_n; c++) begin
         rdy = (scnt < stall) ? 1'b0 : ($urandom_range(0, 3) != 0);
         if (bus.rsp_valid && scnt < stall) scnt++;
         bus.rsp_ready = rdy;
         if (pv && !pa && (!bus.rsp_valid || bus.rsp_data !== pd)) o.held_ok = 1'b0;
         if (bus.rsp_valid && (bus.cmd_ready || !busy)) ready_bad = 1'b1;
         if (bus.rsp_valid && rdy && got < 4) begin o.rsp[got] = bus.rsp_data; got++; end
         pv = bus.rsp_valid; pd = bus.rsp_data; pa = bus.rsp_valid && rdy;
         @(negedge clk);
      end
      o.nrsp = got;
      bus.rsp_ready = 1'b1;
      repeat (4) begin
         if (bus.rsp_valid || busy) o.tail_bad = 1'b1;
         @(negedge clk);
      end
      bus.rsp_ready = 1'b0;
      repeat (2) @(negedge clk);
      if (op == 8'h01) begin
         o.len = w_len; o.dly = w_first - acc; o.addr = w_addr; o.data = w_data;
         o.strb = w_strb; o.stable = w_stable;
      end else if (op == 8'h02) begin
         o.len = r_len; o.dly = r_first - acc; o.addr = r_addr; o.stable = r_stable;
      end
      o.delta = (w_count - wc0) + (r_count - rc0);
   endtask

   task automatic test_reset();
      bus.cmd_valid = 1'b0; bus.cmd_data = '0; bus.rsp_ready = 1'b0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      n_checks++;
      if (bus.cmd_ready !== 1'b0 || bus.rsp_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_handshake: cmd_ready=%b rsp_valid=%b, expected 0 0", bus.cmd_ready, bus.rsp_valid);
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      n_checks++;
      if (bus.cmd_ready !== 1'b1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_idle: cmd_ready=%b busy=%b, expected 1 0", bus.cmd_ready, busy);
      end
      n_checks++;
      if (bus.lb_wen !== 1'b0 || bus.lb_ren !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.rsp_data !== 8'h00) begin
         n_fail++;
         $display("FAIL rst_ctrl: wen=%b ren=%b rsp_valid=%b rsp_data=%h, expected 0 0 0 00",
                  bus.lb_wen, bus.lb_ren, bus.rsp_valid, bus.rsp_data);
      end
      n_checks++;
      if ({bus.lb_waddr, bus.lb_raddr, bus.lb_wdata, bus.lb_wstrb} !== '0) begin
         n_fail++;
         $display("FAIL rst_bus: waddr=%h raddr=%h wdata=%h wstrb=%b, expected all 0",
                  bus.lb_waddr, bus.lb_raddr, bus.lb_wdata, bus.lb_wstrb);
      end
      @(negedge clk);
   endtask

   task automatic test_write();
      obs_t o;
      do_txn(8'h01, 8'h04, 16'h1234, 8'h03, 0, 1'b0, 0, 1, o);
      n_checks++;
      if (o.nrsp !== 1 || o.rsp !== 32'h0 || !o.send_ok) begin
         n_fail++; $display("FAIL t1_rsp: got n=%0d %h send_ok=%b, expected n=1 00000000", o.nrsp, o.rsp, o.send_ok);
      end
      n_checks++;
      if (o.len !== 1 || o.dly !== 1) begin
         n_fail++; $display("FAIL t1_wen_timing: len=%0d delay=%0d, expected 1 1", o.len, o.dly);
      end
      n_checks++;
      if (o.addr !== 8'h04 || o.data !== 16'h1234 || o.strb !== 2'b11) begin
         n_fail++; $display("FAIL t1_wbus: addr=%h data=%h strb=%b, expected 04 1234 11", o.addr, o.data, o.strb);
      end
   endtask

   task automatic test_read();
      obs_t o;
      do_txn(8'h02, 8'h00, 16'h0111, 8'h00, 1, 1'b0, 0, 3, o);
      n_checks++;
      if (o.nrsp !== 3 || o.rsp !== 32'h0001_1100) begin
         n_fail++; $display("FAIL t2_rsp: got n=%0d %h, expected n=3 00011100", o.nrsp, o.rsp);
      end
      n_checks++;
      if (o.len !== 2 || o.dly !== 1 || o.addr !== 8'h00) begin
         n_fail++; $display("FAIL t2_ren: len=%0d delay=%0d raddr=%h, expected 2 1 00", o.len, o.dly, o.addr);
      end
      do_txn(8'h02, 8'h3C, 16'hBEEF, 8'h00, 10, 1'b0, 0, 3, o);
      n_checks++;
      if (o.nrsp !== 3 || o.rsp !== 32'h00BE_EF00) begin
         n_fail++; $display("FAIL t3_rsp: got n=%0d %h, expected n=3 00beef00", o.nrsp, o.rsp);
      end
      n_checks++;
      if (o.len !== 11 || !o.stable || o.addr !== 8'h3C) begin
         n_fail++; $display("FAIL t3_ren: len=%0d stable=%b raddr=%h, expected 11 1 3c", o.len, o.stable, o.addr);
      end
   endtask

   task automatic test_timeout();
      obs_t o;
      do_txn(8'h02, 8'h11, 16'hAAAA, 8'h00, 0, 1'b1, 0, 3, o);
      n_checks++;
      if (o.nrsp !== 3 || o.rsp !== 32'h0000_0001 || o.len !== 256) begin
         n_fail++; $display("FAIL t4_rd_timeout: n=%0d rsp=%h len=%0d, expected 3 00000001 256", o.nrsp, o.rsp, o.len);
      end
      do_txn(8'h02, 8'h12, 16'h5AA5, 8'h00, TIMEOUT, 1'b0, 0, 3, o);
      n_checks++;
      if (o.nrsp !== 3 || o.rsp !== 32'h005A_A500 || o.len !== 256) begin
         n_fail++; $display("FAIL t4_tie: n=%0d rsp=%h len=%0d, expected 3 005aa500 256", o.nrsp, o.rsp, o.len);
      end
      do_txn(8'h01, 8'h13, 16'h0F0F, 8'h01, 0, 1'b1, 0, 1, o);
      n_checks++;
      if (o.nrsp !== 1 || o.rsp !== 32'h0000_0001 || o.len !== 256) begin
         n_fail++; $display("FAIL t4_wr_timeout: n=%0d rsp=%h len=%0d, expected 1 00000001 256", o.nrsp, o.rsp, o.len);
      end
   endtask

   task automatic test_bad_opcode();
      obs_t o;
      do_txn(8'h7E, 8'h00, 16'h0000, 8'h00, 0, 1'b0, 0, 1, o);
      n_checks++;
      if (o.nrsp !== 1 || o.rsp !== 32'h0000_00FF || o.delta !== 0 || o.tail_bad) begin
         n_fail++; $display("FAIL t5_bad: n=%0d rsp=%h lb_txns=%0d tail_bad=%b, expected 1 000000ff 0 0",
                            o.nrsp, o.rsp, o.delta, o.tail_bad);
      end
      do_txn(8'h02, 8'h5A, 16'hC3A5, 8'h00, 2, 1'b0, 0, 3, o);
      n_checks++;
      if (o.nrsp !== 3 || o.rsp !== 32'h00C3_A500 || o.len !== 3) begin
         n_fail++; $display("FAIL t5_next_read: n=%0d rsp=%h len=%0d, expected 3 00c3a500 3", o.nrsp, o.rsp, o.len);
      end
   endtask

   task automatic test_backpressure();
      obs_t o;
      do_txn(8'h02, 8'h77, 16'h9ABC, 8'h00, 3, 1'b0, 20, 3, o);
      n_checks++;
      if (o.nrsp !== 3 || o.rsp !== 32'h009A_BC00 || !o.held_ok || o.tail_bad) begin
         n_fail++; $display("FAIL t6_stall: n=%0d rsp=%h held=%b tail_bad=%b, expected 3 009abc00 1 0",
                            o.nrsp, o.rsp, o.held_ok, o.tail_bad);
      end
   endtask

   task automatic test_reset_mid_write();
      bit ok, seen, bad;
      int acc;
      sl_never = 1'b1;
      send_byte(8'h01, ok, acc);
      send_byte(8'h42, ok, acc);
      send_byte(8'hCD, ok, acc);
      send_byte(8'hAB, ok, acc);
      send_byte(8'h03, ok, acc);
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         if (bus.lb_wen) seen = 1'b1;
         else @(negedge clk);
      end
      n_checks++;
      if (!seen) begin n_fail++; $display("FAIL t6_wen_seen: wen=0, expected 1 before reset"); end
      repeat (3) @(negedge clk);
      rst = 1'b1;
      #1;
      n_checks++;
      if (bus.cmd_ready !== 1'b0 || bus.rsp_valid !== 1'b0) begin
         n_fail++; $display("FAIL t6_rst_cycle: cmd_ready=%b rsp_valid=%b, expected 0 0", bus.cmd_ready, bus.rsp_valid);
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      n_checks++;
      if (bus.lb_wen !== 1'b0 || busy !== 1'b0 || bus.cmd_ready !== 1'b1) begin
         n_fail++; $display("FAIL t6_after_rst: wen=%b busy=%b cmd_ready=%b, expected 0 0 1", bus.lb_wen, busy, bus.cmd_ready);
      end
      bus.rsp_ready = 1'b1;
      bad = 1'b0;
      repeat (10) begin
         @(negedge clk);
         if (bus.rsp_valid || bus.lb_wen) bad = 1'b1;
      end
      bus.rsp_ready = 1'b0;
      sl_never = 1'b0;
      n_checks++;
      if (bad) begin n_fail++; $display("FAIL t6_no_rsp: rsp_valid/wen seen after reset, expected none"); end
   endtask

   task automatic test_random();
      obs_t        o;
      logic [7:0]  op, addr, strb;
      logic [15:0] data;
      logic [31:0] er;
      int          lat, stall, en, elen, eused, r;
      bit          never;
      for (int t = 0; t < 30; t++) begin
         r = $urandom_range(0, 9);
         op = (r < 4) ? 8'h01 : (r < 8) ? 8'h02 : 8'($urandom);
         if (r >= 8 && (op == 8'h01 || op == 8'h02)) op = 8'h80;
         addr = 8'($urandom); data = 16'($urandom); strb = 8'($urandom);
         lat = $urandom_range(0, 8); never = ($urandom_range(0, 11) == 0);
         stall = $urandom_range(0, 3);
         model(op, data, lat, never, en, er, elen, eused);
         do_txn(op, addr, data, strb, lat, never, stall, en, o);
         n_checks++;
         if (o.nrsp !== en || o.rsp !== er || !o.send_ok) begin
            n_fail++; $display("FAIL rnd_rsp[%0d] op=%h: n=%0d %h send_ok=%b, expected n=%0d %h",
                               t, op, o.nrsp, o.rsp, o.send_ok, en, er);
         end
         n_checks++;
         if (!o.held_ok || o.tail_bad || o.delta !== eused) begin
            n_fail++; $display("FAIL rnd_flow[%0d]: held=%b tail_bad=%b lb_txns=%0d, expected 1 0 %0d",
                               t, o.held_ok, o.tail_bad, o.delta, eused);
         end
         if (eused != 0) begin
            n_checks++;
            if (o.len !== elen || o.dly !== 1 || !o.stable || o.addr !== addr) begin
               n_fail++; $display("FAIL rnd_lb[%0d]: len=%0d delay=%0d stable=%b addr=%h, expected %0d 1 1 %h",
                                  t, o.len, o.dly, o.stable, o.addr, elen, addr);
            end
         end
         if (op == 8'h01) begin
            n_checks++;
            if (o.data !== data || o.strb !== strb[1:0]) begin
               n_fail++; $display("FAIL rnd_wbus[%0d]: data=%h strb=%b, expected %h %b", t, o.data, o.strb, data, strb[1:0]);
            end
         end
      end
      n_checks++;
      if (ready_bad) begin n_fail++; $display("FAIL cmd_ready_busy: cmd_ready high or busy low during bus/response phase"); end
   endtask

   initial begin
      bus.cmd_valid = 1'b0;
      bus.cmd_data  = '0;
      bus.rsp_ready = 1'b0;
      test_reset();
      test_write();
      test_read();
      test_timeout();
      test_bad_opcode();
      test_backpressure();
      test_reset_mid_write();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
